// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: operand width and divider FSM state encodings.
package arith_pkg;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

endpackage : arith_pkg

// File: rtl/four_bit_subtractor.sv
// Combinational 4-bit ripple-borrow subtractor: diff = a - b - bin, bout = borrow out.
module four_bit_subtractor
    import arith_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    logic borrow;

    always_comb begin
        diff   = '0;
        borrow = bin;
        for (int i = 0; i < int'(WIDTH); i++) begin
            diff[i] = a[i] ^ b[i] ^ borrow;
            borrow  = (~a[i] & (b[i] | borrow)) | (b[i] & borrow);
        end
        bout = borrow;
    end

endmodule : four_bit_subtractor

// File: rtl/restoring_divider_4bit.sv
// Sequential 4-bit unsigned restoring divider, one trial subtraction per clock,
// with a start/busy/done handshake and a divide-by-zero shortcut.
module restoring_divider_4bit
    import arith_pkg::*;
#(
    parameter logic [WIDTH-1:0] DBZ_QUOTIENT = 4'hF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_sh_q, quo_sh_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] sub_diff;
    logic             sub_bout;
    logic             accept;

    four_bit_subtractor u_sub (
        .a    (shifted[WIDTH-1:0]),
        .b    (dvs_q),
        .bin  (1'b0),
        .diff (sub_diff),
        .bout (sub_bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dvs_q       <= '0;
            quo_sh_q    <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvs_q       <= dvs_d;
            quo_sh_q    <= quo_sh_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    // A set top bit of the shifted remainder means S >= 16 > D, so the step always accepts.
    always_comb begin
        state_d     = state_q;
        dvs_d       = dvs_q;
        quo_sh_d    = quo_sh_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        shifted     = {rem_q, quo_sh_q[WIDTH-1]};
        accept      = shifted[WIDTH] | ~sub_bout;

        case (state_q)
            ST_RUN: begin
                rem_d    = accept ? sub_diff : shifted[WIDTH-1:0];
                quo_sh_d = {quo_sh_q[WIDTH-2:0], accept};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d     = ST_FIN;
                    quotient_d  = quo_sh_d;
                    remainder_d = rem_d;
                    dbz_d       = 1'b0;
                end
            end
            ST_IDLE, ST_FIN: begin
                state_d = ST_IDLE;
                if (start) begin
                    dvs_d    = divisor;
                    quo_sh_d = dividend;
                    rem_d    = '0;
                    cnt_d    = '0;
                    if (divisor == '0) begin
                        state_d     = ST_FIN;
                        quotient_d  = DBZ_QUOTIENT;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule : restoring_divider_4bit

// File: tb/tb_restoring_divider_4bit.sv
// Directed and exhaustive checks of restoring_divider_4bit against hand-computed and / % results.
module tb_restoring_divider_4bit;

    logic       clk;
    logic       clk_en;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [3:0] prev_q;
    logic [3:0] prev_r;
    logic       prev_z;

    restoring_divider_4bit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns the falling-edge count at which done was seen.
    task automatic wait_done(input int lat_start, output int lat);
        lat = lat_start;
        forever begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk("busy_in_flight", 8'(busy), 8'd1);
            if (done === 1'b1) break;
            if (lat == 2) begin
                chk("hold_quotient", 8'(quotient), 8'(prev_q));
                chk("hold_remainder", 8'(remainder), 8'(prev_r));
                chk("hold_dbz", 8'(div_by_zero), 8'(prev_z));
            end
            if (lat >= 20) begin
                chk("done_timeout", 8'(done), 8'd1);
                break;
            end
        end
    endtask

    task automatic check_result(input logic [3:0] a, input logic [3:0] b, input int lat);
        logic [3:0] eq;
        logic [3:0] er;
        logic       ez;
        int         el;
        if (b == 4'd0) begin
            eq = 4'hF; er = a; ez = 1'b1; el = 1;
        end else begin
            eq = a / b; er = a % b; ez = 1'b0; el = 5;
        end
        chk($sformatf("latency_%0d_%0d", a, b), 8'(lat), 8'(el));
        chk($sformatf("quotient_%0d_%0d", a, b), 8'(quotient), 8'(eq));
        chk($sformatf("remainder_%0d_%0d", a, b), 8'(remainder), 8'(er));
        chk($sformatf("dbz_%0d_%0d", a, b), 8'(div_by_zero), 8'(ez));
        prev_q = eq;
        prev_r = er;
        prev_z = ez;
    endtask

    task automatic idle_after_done();
        @(negedge clk);
        chk("done_single_pulse", 8'(done), 8'd0);
        chk("busy_back_idle", 8'(busy), 8'd0);
    endtask

    task automatic do_div(input logic [3:0] a, input logic [3:0] b);
        int lat;
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
        wait_done(0, lat);
        check_result(a, b, lat);
        idle_after_done();
    endtask

    initial begin
        int lat;
        int done_cnt;
        clk_en = 1'b0;
        rst = 1'b0; start = 1'b0; dividend = 4'd0; divisor = 4'd0;
        prev_q = 4'd0; prev_r = 4'd0; prev_z = 1'b0;

        // Asynchronous reset with the clock idle.
        #2 rst = 1'b1;
        #3;
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_quotient", 8'(quotient), 8'd0);
        chk("rst_remainder", 8'(remainder), 8'd0);
        chk("rst_dbz", 8'(div_by_zero), 8'd0);
        clk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 8'(busy), 8'd0);

        do_div(4'd13, 4'd3);
        do_div(4'd15, 4'd8);
        do_div(4'd15, 4'd1);
        do_div(4'd9, 4'd12);
        do_div(4'd7, 4'd0);
        do_div(4'd6, 4'd2);

        // Second start during RUN is ignored.
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; dividend = 4'd8; divisor = 4'd2;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(2, lat);
        check_result(4'd13, 4'd3, lat);
        idle_after_done();

        // Start held through FIN gives a back-to-back run.
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(posedge clk);
        #1 dividend = 4'd14; divisor = 4'd4;
        wait_done(0, lat);
        check_result(4'd13, 4'd3, lat);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(0, lat);
        check_result(4'd14, 4'd4, lat);
        idle_after_done();

        // Reset in the third RUN cycle aborts the division.
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 8'(busy), 8'd0);
        chk("abort_done", 8'(done), 8'd0);
        chk("abort_quotient", 8'(quotient), 8'd0);
        chk("abort_remainder", 8'(remainder), 8'd0);
        chk("abort_dbz", 8'(div_by_zero), 8'd0);
        prev_q = 4'd0; prev_r = 4'd0; prev_z = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        chk("abort_no_done", 8'(done_cnt), 8'd0);
        chk("abort_idle", 8'(busy), 8'd0);
        do_div(4'd10, 4'd3);

        // Every operand pair.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_div(4'(a), 4'(b));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_restoring_divider_4bit
